// File: rtl/add_sub_pkg.sv
// Shared widths, op encodings and sign-magnitude helpers for the add_sub arbiter slice.
package add_sub_pkg;

   localparam int unsigned DW_DEF   = 16;
   localparam int unsigned NREQ_DEF = 4;
   localparam int unsigned IDW_DEF  = $clog2(NREQ_DEF);
   localparam int unsigned MW_DEF   = DW_DEF - 1;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Build a sign-magnitude word from a signed integer (magnitude truncates).
   function automatic logic [DW_DEF-1:0] sm_encode(input int value);
      logic        neg;
      int unsigned mag;
      neg = (value < 0);
      mag = unsigned'(neg ? -value : value);
      return {neg, MW_DEF'(mag)};
   endfunction

   // Recover a signed integer from a sign-magnitude word.
   function automatic int sm_decode(input logic [DW_DEF-1:0] code);
      int mag;
      mag = int'(code[MW_DEF-1:0]);
      return code[DW_DEF-1] ? -mag : mag;
   endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational sign-magnitude adder/subtractor; zero results are always +0.
module add_sub #(
   parameter int unsigned DW = 16
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          sel,
   output logic [DW-1:0] res_c
);

   localparam int unsigned MW = DW - 1;

   logic          sa;
   logic          sb;
   logic          sr;
   logic [MW-1:0] ma;
   logic [MW-1:0] mb;
   logic [MW-1:0] mr;

   // Subtraction flips the sign of b; like signs add magnitudes, unlike signs subtract the smaller.
   always_comb begin
      sa = a[DW-1];
      sb = b[DW-1] ^ sel;
      ma = a[MW-1:0];
      mb = b[MW-1:0];
      mr = '0;
      sr = 1'b0;
      if (sa == sb) begin
         mr = ma + mb;
         sr = sa;
      end else if (ma >= mb) begin
         mr = ma - mb;
         sr = sa;
      end else begin
         mr = mb - ma;
         sr = sb;
      end
      if (mr == '0) begin
         sr = 1'b0;
      end
      res_c = {sr, mr};
   end

endmodule

// File: rtl/rr_arb.sv
// Round-robin grant: first requester at or after ptr wins; ptr advances past a granted index.
module rr_arb #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]          req,
   input  logic [$clog2(NREQ)-1:0]  ptr,
   input  logic                     enable,
   output logic [NREQ-1:0]          grant,
   output logic [$clog2(NREQ)-1:0]  gnt_idx,
   output logic [$clog2(NREQ)-1:0]  next_ptr
);

   localparam int unsigned IDW = $clog2(NREQ);

   logic found;

   // Rotating priority scan, then gate the one-hot grant and pointer advance with enable.
   always_comb begin
      int unsigned scan;
      scan     = 0;
      grant    = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      next_ptr = ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan = (32'(ptr) + k) % NREQ;
         if (!found && req[IDW'(scan)]) begin
            found   = 1'b1;
            gnt_idx = IDW'(scan);
         end
      end
      if (found && enable) begin
         grant[gnt_idx] = 1'b1;
         next_ptr       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : IDW'(gnt_idx + 1'b1);
      end
   end

endmodule

// File: rtl/add_sub_arb.sv
// Shares one add_sub datapath among NREQ requesters via round-robin issue and a two-stage pipe.
module add_sub_arb
   import add_sub_pkg::*;
#(
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   input  logic [NREQ-1:0]    req_sel,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DW-1:0]      rsp_data,
   output logic [IDW-1:0]     rsp_id
);

   logic            v1;
   logic [DW-1:0]   a1;
   logic [DW-1:0]   b1;
   logic            sel1;
   logic [IDW-1:0]  id1;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  next_ptr;
   logic [IDW-1:0]  gnt_idx;
   logic [NREQ-1:0] grant;
   logic [DW-1:0]   res_c;
   logic            s2_load;
   logic            s1_load;
   logic            arb_en;

   // Each stage may load when it is empty or the stage after it is moving.
   assign s2_load   = !rsp_valid || rsp_ready;
   assign s1_load   = !v1 || s2_load;
   assign arb_en    = s1_load && !rst;
   assign req_ready = grant;

   rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .req      (req_valid),
      .ptr      (ptr),
      .enable   (arb_en),
      .grant    (grant),
      .gnt_idx  (gnt_idx),
      .next_ptr (next_ptr)
   );

   add_sub #(
      .DW (DW)
   ) u_add_sub (
      .a     (a1),
      .b     (b1),
      .sel   (sel1),
      .res_c (res_c)
   );

   // Issue stage: capture the granted requester's operands and advance the pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         a1   <= '0;
         b1   <= '0;
         sel1 <= 1'b0;
         id1  <= '0;
         ptr  <= '0;
      end else begin
         if (s1_load) begin
            v1 <= |req_valid;
         end
         if (|grant) begin
            a1   <= req_a[32'(gnt_idx)*DW +: DW];
            b1   <= req_b[32'(gnt_idx)*DW +: DW];
            sel1 <= req_sel[gnt_idx];
            id1  <= gnt_idx;
         end
         ptr <= next_ptr;
      end
   end

   // Output stage: register the datapath result; payload holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else if (s2_load) begin
         rsp_valid <= v1;
         if (v1) begin
            rsp_data <= res_c;
            rsp_id   <= id1;
         end
      end
   end

endmodule
